// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman movement controller: direction codes,
// coordinate width and FSM state encoding.
package pacman_pkg;

   localparam int unsigned COORD_W = 9;
   localparam int unsigned DIR_W   = 4;
   localparam int unsigned TICK_W  = 24;

   localparam logic [DIR_W-1:0] DIR_L    = 4'b1000;
   localparam logic [DIR_W-1:0] DIR_U    = 4'b0100;
   localparam logic [DIR_W-1:0] DIR_R    = 4'b0010;
   localparam logic [DIR_W-1:0] DIR_D    = 4'b0001;
   localparam logic [DIR_W-1:0] DIR_NONE = 4'b0000;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_WAIT_REQ = 2'd1;
   localparam state_t ST_WAIT_CUR = 2'd2;

   function automatic logic is_one_hot(input logic [DIR_W-1:0] v);
      return (v == DIR_L) || (v == DIR_U) || (v == DIR_R) || (v == DIR_D);
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running STEP_DIV counter; tick is high for the one cycle where the
// count equals STEP_DIV-1.
module move_tick_gen
   import pacman_pkg::*;
#(
   parameter logic [TICK_W-1:0] STEP_DIV = 24'd2_500_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [TICK_W-1:0] count_q, count_d;
   logic              tick_q, tick_d;

   // tick is registered from the next count so it lines up with count_q
   always_comb begin
      count_d = (count_q == STEP_DIV - TICK_W'(1)) ? '0 : count_q + TICK_W'(1);
      tick_d  = (count_d == STEP_DIV - TICK_W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/pacman_mover.sv
// Pacman movement controller: queries the collision checker on each tick and
// steps one tile. Define PACMAN_TUNNEL_WRAP_EN to wrap X at the tunnel edges.
module pacman_mover
   import pacman_pkg::*;
#(
   parameter logic [COORD_W-1:0] START_X   = 9'd14,
   parameter logic [COORD_W-1:0] START_Y   = 9'd23,
   parameter logic [TICK_W-1:0]  STEP_DIV  = 24'd2_500_000,
   parameter int unsigned        QUERY_LAT = 2,
   parameter logic [COORD_W-1:0] X_MIN     = 9'd0,
   parameter logic [COORD_W-1:0] X_MAX     = 9'd27
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIR_W-1:0]   key_req,
   input  logic               collide,
   output logic [DIR_W-1:0]   query_dir,
   output logic [COORD_W-1:0] p_x,
   output logic [COORD_W-1:0] p_y,
   output logic [DIR_W-1:0]   cur_dir,
   output logic               moved
);

   localparam int unsigned WAIT_W = (QUERY_LAT < 1) ? 1 : $clog2(QUERY_LAT + 1);

   logic               tick;
   state_t             state_q, state_d;
   logic [DIR_W-1:0]   req_q, req_d;
   logic [DIR_W-1:0]   cur_q, cur_d;
   logic [DIR_W-1:0]   query_q, query_d;
   logic [COORD_W-1:0] px_q, px_d;
   logic [COORD_W-1:0] py_q, py_d;
   logic               moved_q, moved_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;

   logic [COORD_W-1:0] step_x_c, step_y_c;
   logic               oob_c, blocked_c, wait_done_c, do_step_c;

   move_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Target tile for the direction currently under query
   always_comb begin
      step_x_c = px_q;
      step_y_c = py_q;
      oob_c    = 1'b0;
      case (query_q)
         DIR_L: begin
            if (px_q == X_MIN) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
               step_x_c = X_MAX;
`else
               oob_c    = 1'b1;
`endif
            end else begin
               step_x_c = px_q - COORD_W'(1);
            end
         end
         DIR_R: begin
            if (px_q == X_MAX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
               step_x_c = X_MIN;
`else
               oob_c    = 1'b1;
`endif
            end else begin
               step_x_c = px_q + COORD_W'(1);
            end
         end
         DIR_U:   step_y_c = py_q - COORD_W'(1);
         DIR_D:   step_y_c = py_q + COORD_W'(1);
         default: ;
      endcase
   end

   assign blocked_c   = collide | oob_c;
   assign wait_done_c = (wait_q == WAIT_W'(QUERY_LAT));

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      req_d     = is_one_hot(key_req) ? key_req : req_q;
      cur_d     = cur_q;
      query_d   = query_q;
      px_d      = px_q;
      py_d      = py_q;
      moved_d   = 1'b0;
      wait_d    = wait_q;
      do_step_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            wait_d = '0;
            if (tick) begin
               if ((req_q != DIR_NONE) && (req_q != cur_q)) begin
                  query_d = req_q;
                  state_d = ST_WAIT_REQ;
               end else if (cur_q != DIR_NONE) begin
                  query_d = cur_q;
                  state_d = ST_WAIT_CUR;
               end
            end
         end
         ST_WAIT_REQ: begin
            if (!wait_done_c) begin
               wait_d = wait_q + WAIT_W'(1);
            end else begin
               wait_d = '0;
               if (!blocked_c) begin
                  cur_d     = query_q;
                  do_step_c = 1'b1;
                  state_d   = ST_IDLE;
               end else if (cur_q != DIR_NONE) begin
                  query_d = cur_q;
                  state_d = ST_WAIT_CUR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_CUR: begin
            if (!wait_done_c) begin
               wait_d = wait_q + WAIT_W'(1);
            end else begin
               wait_d    = '0;
               do_step_c = !blocked_c;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_step_c) begin
         px_d    = step_x_c;
         py_d    = step_y_c;
         moved_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= DIR_NONE;
         cur_q   <= DIR_NONE;
         query_q <= DIR_NONE;
         px_q    <= START_X;
         py_q    <= START_Y;
         moved_q <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cur_q   <= cur_d;
         query_q <= query_d;
         px_q    <= px_d;
         py_q    <= py_d;
         moved_q <= moved_d;
         wait_q  <= wait_d;
      end
   end

   assign query_dir = query_q;
   assign p_x       = px_q;
   assign p_y       = py_q;
   assign cur_dir   = cur_q;
   assign moved     = moved_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: a latency-2 collision checker model plus a
// per-tick transaction model of the movement rules.
module tb_pacman_mover;
   import pacman_pkg::*;

   localparam logic [23:0] SD  = 24'd16;
   localparam int          QL  = 2;
   localparam int          PER = 16;
   localparam logic [8:0]  XMN = 9'd0;
   localparam logic [8:0]  XMX = 9'd27;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_req = 4'b0000;
   logic       collide;
   logic [3:0] query_dir, cur_dir;
   logic [8:0] p_x, p_y;
   logic       moved;

   pacman_mover #(
      .START_X(9'd14), .START_Y(9'd23), .STEP_DIV(SD), .QUERY_LAT(QL),
      .X_MIN(XMN), .X_MAX(XMX)
   ) dut (
      .clk(clk), .rst(rst), .key_req(key_req), .collide(collide),
      .query_dir(query_dir), .p_x(p_x), .p_y(p_y), .cur_dir(cur_dir),
      .moved(moved)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // maze: 0 random map, 1 all free, 2 blocked for directions in block_mask
   int          mode = 1;
   logic [3:0]  block_mask = 4'b0000;
   logic [63:0] wall_map;

   logic [3:0] req_m = 4'b0000, cur_m = 4'b0000, lastq_m = 4'b0000;
   logic [8:0] x_m = 9'd14, y_m = 9'd23;

   function automatic logic wall(input logic [3:0] d, input logic [8:0] x, input logic [8:0] y);
      int idx;
      if (mode == 0) begin
         idx = (int'(x) * 5 + int'(y) * 11 + int'(d) * 7) % 64;
         return wall_map[idx];
      end else if (mode == 1) begin
         return 1'b0;
      end
      return (d & block_mask) != 4'b0000;
   endfunction

   logic c1 = 1'b0, c2 = 1'b0;
   always @(posedge clk) begin
      c1 <= wall(query_dir, p_x, p_y);
      c2 <= c1;
   end
   assign collide = c2;

   function automatic logic onehot(input logic [3:0] v);
      return v == 4'b1000 || v == 4'b0100 || v == 4'b0010 || v == 4'b0001;
   endfunction

   // Would a step in d from the model position succeed, and where to
   function automatic void model_try(input logic [3:0] d, output logic ok,
                                     output logic [8:0] nx, output logic [8:0] ny);
      ok = !wall(d, x_m, y_m);
      nx = x_m;
      ny = y_m;
      if (d == 4'b1000) begin
         if (x_m == XMN) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
            nx = XMX;
`else
            ok = 1'b0;
`endif
         end else nx = x_m - 9'd1;
      end else if (d == 4'b0010) begin
         if (x_m == XMX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
            nx = XMN;
`else
            ok = 1'b0;
`endif
         end else nx = x_m + 9'd1;
      end else if (d == 4'b0100) ny = y_m - 9'd1;
      else if (d == 4'b0001) ny = y_m + 9'd1;
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered #1 after the edge that starts a tick cycle; leaves at the next one
   task automatic run_period(input logic [3:0] next_key);
      logic [3:0] q1, q2;
      logic       ok;
      logic [8:0] nx, ny;
      int         step_c;
      q1 = lastq_m;
      q2 = lastq_m;
      step_c = -1;
      if (req_m != 4'b0000 && req_m != cur_m) begin
         q1 = req_m;
         q2 = req_m;
         model_try(req_m, ok, nx, ny);
         if (ok) begin
            step_c = QL + 2;
            cur_m  = req_m;
         end else if (cur_m != 4'b0000) begin
            q2 = cur_m;
            model_try(cur_m, ok, nx, ny);
            if (ok) step_c = 2 * QL + 3;
         end
      end else if (cur_m != 4'b0000) begin
         q1 = cur_m;
         q2 = cur_m;
         model_try(cur_m, ok, nx, ny);
         if (ok) step_c = QL + 2;
      end
      lastq_m = q2;
      if (step_c >= 0) begin
         x_m = nx;
         y_m = ny;
      end
      for (int c = 1; c <= PER; c++) begin
         @(posedge clk);
         #1;
         if (c < PER) begin
            if (c == 1) chk("query_first", {5'd0, query_dir}, {5'd0, q1});
            if (c == QL + 2) chk("query_second", {5'd0, query_dir}, {5'd0, q2});
            chk("moved", {8'd0, moved}, 9'(c == step_c));
            if (c == 10) begin
               key_req = next_key;
               if (onehot(next_key)) req_m = next_key;
            end
            if (c == PER - 1) begin
               chk("p_x", p_x, x_m);
               chk("p_y", p_y, y_m);
               chk("cur_dir", {5'd0, cur_dir}, {5'd0, cur_m});
            end
         end
      end
   endtask

   initial begin
      logic [3:0] keys [7];
      keys[0] = 4'b1000; keys[1] = 4'b0100; keys[2] = 4'b0010; keys[3] = 4'b0001;
      keys[4] = 4'b0000; keys[5] = 4'b0110; keys[6] = 4'b1111;
      wall_map = {$urandom(), $urandom()};

      key_req = 4'b0110;
      #22 rst = 1'b0;
      #1;
      chk("rst_p_x", p_x, 9'd14);
      chk("rst_p_y", p_y, 9'd23);
      chk("rst_cur", {5'd0, cur_dir}, 9'd0);
      chk("rst_query", {5'd0, query_dir}, 9'd0);
      chk("rst_moved", {8'd0, moved}, 9'd0);

      repeat (PER - 1) @(posedge clk);
      #1;

      // invalid keys with nothing committed: no queries
      run_period(4'b0000);
      run_period(4'b0010);
      // free right request
      run_period(4'b0100);
      // up blocked, fall back to right
      mode = 2; block_mask = 4'b0100;
      run_period(4'b0100);
      // everything blocked
      block_mask = 4'b1111;
      run_period(4'b1000);
      run_period(4'b1000);
      // walk left into the tunnel edge
      mode = 1;
      repeat (19) run_period(4'b1000);
      // random maze and keys
      mode = 0;
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) wall_map = {$urandom(), $urandom()};
         run_period(keys[$urandom_range(0, 6)]);
      end
      mode = 1;
      run_period(4'b0010);

      // asynchronous reset in the middle of a query
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_p_x", p_x, 9'd14);
      chk("mid_rst_p_y", p_y, 9'd23);
      chk("mid_rst_cur", {5'd0, cur_dir}, 9'd0);
      chk("mid_rst_query", {5'd0, query_dir}, 9'd0);
      chk("mid_rst_moved", {8'd0, moved}, 9'd0);
      #3 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         chk("post_rst_moved", {8'd0, moved}, 9'd0);
         chk("post_rst_p_x", p_x, 9'd14);
         chk("post_rst_query", {5'd0, query_dir}, 9'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Movement controller for the Pacman sprite. It latches one-hot direction requests from the keypad and issues direction queries to the collision checker at every movement tick. It then commits a one-tile step in the requested direction, or in the current direction, or holds position. It is the initiator side of the collision_detection query interface: it drives `query_dir` and the position, and consumes `collide`.

## Interface
Parameters:
- `START_X`, default 9'd14: reset tile column.
- `START_Y`, default 9'd23: reset tile row.
- `STEP_DIV`, default 24'd2_500_000: clocks per movement tick.
- `QUERY_LAT`, default 2: clock edges from a `query_dir`/position change until `collide` reflects it.
- `X_MIN`, default 9'd0: column limit used for the tunnel edge.
- `X_MAX`, default 9'd27: column limit used for the tunnel edge.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_req` in 4: one-hot request; 1000=L, 0100=U, 0010=R, 0001=D.
- `collide` in 1: 1 means the queried direction is blocked.
- `query_dir` out 4: direction under test, sent to the collision checker.
- `p_x` out 9: current tile column.
- `p_y` out 9: current tile row.
- `cur_dir` out 4: committed direction of travel.
- `moved` out 1: one-cycle pulse when the position changes.

## Operation
- Request latch: when `key_req` is exactly one-hot, it is captured into `req_dir` every cycle. Codes 0000 and multi-hot are ignored, and `req_dir` holds its value.
- Tick: a free-running counter counts 0..STEP_DIV-1. `tick` is high while the count equals STEP_DIV-1, then the count wraps to 0.
- FSM states:
  - IDLE.
  - WAIT_REQ.
  - WAIT_CUR.
  - WAIT_CUR is followed by a return to IDLE.
- IDLE, on tick:
  - If `req_dir`≠0 and `req_dir`≠`cur_dir`: `query_dir`←`req_dir`, go to WAIT_REQ.
  - Else if `cur_dir`≠0: `query_dir`←`cur_dir`, go to WAIT_CUR.
  - Else stay in IDLE.
- Waiting: a wait counter runs for QUERY_LAT cycles after `query_dir` is set. `collide` is sampled on the following edge.
- WAIT_REQ, free: `cur_dir`←`req_dir`, step, go to IDLE.
- WAIT_REQ, blocked: if `cur_dir`≠0, set `query_dir`←`cur_dir` and go to WAIT_CUR; else go to IDLE.
- WAIT_CUR, free: step, go to IDLE.
- WAIT_CUR, blocked: go to IDLE with no step; `cur_dir` is held so facing is retained.
- Step arithmetic:
  - L: x-1. R: x+1. U: y-1. D: y+1.
  - 9-bit values; no change to the other axis.
  - `moved`=1 for exactly one cycle.
- Positions change only on step edges, so `p_x`/`p_y` stay stable throughout every query.
- `query_dir` stays stable during a wait. `req_dir` may update mid-query; the new value is used at the next tick.
- Ticks arriving outside IDLE are dropped; the counter is unaffected. STEP_DIV must be ≥ 2*QUERY_LAT+4.
- When `req_dir` = `cur_dir`, only the current direction is queried.

## Timing
- Reset values:
  - `p_x`=START_X, `p_y`=START_Y.
  - `cur_dir`=`req_dir`=`query_dir`=0000.
  - `moved`=0.
  - FSM in IDLE; tick and wait counters 0.
- Reset mid-query aborts immediately; no step occurs.
- Latency with the tick in cycle 0:
  - `query_dir` is valid in cycle 1.
  - The new position and `moved` appear in cycle QUERY_LAT+2 when the request is free.
  - They appear in cycle 2*QUERY_LAT+3 when the fallback on `cur_dir` is taken.
- All outputs are registered.

## Configuration
- `PACMAN_TUNNEL_WRAP_EN` defined:
  - L at `p_x`=X_MIN steps to X_MAX.
  - R at X_MAX steps to X_MIN.
  - `moved` pulses as for a normal step.
- Undefined: a step that would leave [X_MIN, X_MAX] is suppressed, as if `collide` were 1. `moved` stays 0.
- Y never wraps.

## Structure
- Shared package `pacman_pkg`:
  - DIR_L, DIR_U, DIR_R, DIR_D, DIR_NONE (4-bit one-hot).
  - COORD_W=9.
  - FSM state typedef.
- One sub-module, `move_tick_gen`: a STEP_DIV counter emitting the one-cycle `tick`.

## Test plan
- Reset values: assert `rst` asynchronously mid-cycle -> `p_x`=14, `p_y`=23, `cur_dir`=0, `query_dir`=0, `moved`=0 immediately.
- Free request: `key_req`=0010, `collide`=0, tick in cycle 0, QUERY_LAT=2 -> `query_dir`=0010 in cycle 1; `p_x`=15, `cur_dir`=0010 and `moved`=1 in cycle 4 only.
- Fallback: `cur_dir`=R, `key_req`=0100, `collide`=1 while `query_dir`=0100 and 0 otherwise -> `query_dir` changes to 0010; `p_x`+1 in cycle 7; `cur_dir` stays R; `req_dir` stays U.
- Both blocked: `collide`=1 constantly -> no position change, `moved`=0, `cur_dir` unchanged, FSM back in IDLE by cycle 7.
- Invalid key: `key_req`=0110, then 0000 -> `req_dir` unchanged, and no query is issued when `cur_dir`=0.
- Tunnel edge: `p_x`=0, L free -> `p_x`=27 with the macro defined; `p_x`=0 and `moved`=0 without it.
